decoder: RTL and testbench
==========================

# decoder

RV64I instruction decoder for the fetch/decode front end. Accepts one 32-bit instruction word plus its PC per cycle. Returns a registered decode one clock later: architectural fields, sign-extended immediate, a numeric mnemonic ID, branch/jump target, and illegal/halt flags. Sits between the fetch unit, which splits each 64-bit bus beat into two instructions at `pc` and `pc+4`, and the issue/trace logic.

## Interface
Parameters:
- `XLEN`, default 64: width of PC, immediate and target.

Ports (reset is synchronous, active-high; clock is `clk`):
- `clk`, in, 1: clock. All state updates on its rising edge.
- `reset`, in, 1: synchronous, active-high.
- `in_valid`, in, 1: `instr`/`pc` are valid this cycle.
- `instr`, in, 32: instruction word.
- `pc`, in, XLEN: address of `instr`.
- `out_valid`, out, 1: decode outputs are valid.
- `op_id`, out, 6: mnemonic ID (see Operation).
- `rd`, `rs1`, `rs2`, out, 5 each: register fields. Zero when the format does not use them.
- `funct3`, out, 3: `instr[14:12]`.
- `funct7`, out, 7: `instr[31:25]`.
- `imm`, out, XLEN: sign-extended immediate. Zero for R-type and system instructions.
- `target`, out, XLEN: `pc+imm` for branches, JAL and AUIPC; otherwise zero.
- `out_pc`, out, XLEN: registered copy of `pc`.
- `illegal`, out, 1: encoding not recognised.
- `halt`, out, 1: `instr == 32'h0`.

## Operation
- **op_id encoding:**
  - 0 ILLEGAL; 1 LUI; 2 AUIPC; 3 JAL; 4 JALR.
  - 5–10: BEQ BNE BLT BGE BLTU BGEU.
  - 11–17: LB LH LW LD LBU LHU LWU.
  - 18–21: SB SH SW SD.
  - 22–30: ADDI SLTI SLTIU XORI ORI ANDI SLLI SRLI SRAI.
  - 31–40: ADD SUB SLL SLT SLTU XOR SRL SRA OR AND.
  - 41–44: ADDIW SLLIW SRLIW SRAIW.
  - 45–49: ADDW SUBW SLLW SRLW SRAW.
  - 50 FENCE; 51 ECALL; 52 EBREAK; 53 HALT.
- **Decode key:**
  - Primary key is `opcode = instr[6:0]`, refined by funct3 and funct7.
  - 64-bit shift-immediates (SLLI/SRLI/SRAI) use `instr[25:20]` as shamt and check funct6 = `instr[31:26]`: 000000, or 010000 for SRAI.
  - *W shift-immediates require funct7 = 0000000, or 0100000 for SRAIW. Any other value is illegal.
  - R-type funct7 must be 0000000, or 0100000 only for SUB/SRA/SUBW/SRAW.
- **Immediates, all sign-extended from `instr[31]`:**
  - I: `instr[31:20]`.
  - S: `{instr[31:25], instr[11:7]}`.
  - B: `{instr[31], instr[7], instr[30:25], instr[11:8], 0}`.
  - U: `{instr[31:12], 12'b0}`, sign-extended to 64 bits.
  - J: `{instr[31], instr[19:12], instr[20], instr[30:21], 0}`.
  - Shift-immediates: `imm` = zero-extended shamt.
- **Arithmetic:** `target` = `pc + imm`, modulo 2^XLEN. Wrap-around is silent.
- **System instructions:**
  - ECALL requires `instr == 32'h00000073`.
  - EBREAK requires `instr == 32'h00100073`.
  - Any other SYSTEM encoding is illegal.
  - FENCE: opcode 0001111 with funct3 = 000.
- **Zero word:** `instr == 0` gives `op_id` = 53, `halt` = 1, `illegal` = 0.
- **Illegal encodings:** `op_id` = 0, `illegal` = 1. Fields are still extracted, `imm` = 0, `target` = 0.
- **Simulation trace:** each valid output prints one line with `$display`: `out_pc` in hex, `instr` in hex, mnemonic and operands. Not synthesised.

## Timing
- Fully registered, latency 1: `in_valid` sampled at edge N produces `out_valid`=1 with its fields after edge N.
- Throughput is one instruction per cycle, back to back. There is no backpressure.
- When `in_valid`=0, `out_valid` drops to 0 at the next edge. Data fields hold their previous values.
- Reset:
  - All outputs are 0 after any edge with `reset`=1.
  - An input presented on a reset edge is discarded.
  - An in-flight result is cancelled by reset mid-stream.

## Test plan
- ADDI (22), positive immediate: `instr`=0x00500093, `pc`=0x1000, `in_valid`=1 → next cycle `out_valid`=1, `op_id`=22, `rd`=1, `rs1`=0, `imm`=5, `illegal`=0.
- ADDI (22), negative immediate: `instr`=0xFFF00113 → `op_id`=22, `rd`=2, `imm`=0xFFFFFFFFFFFFFFFF.
- BEQ (5) with target: `instr`=0x00208463, `pc`=0x1000 → `op_id`=5, `rs1`=1, `rs2`=2, `imm`=8, `target`=0x1008. Also 0xFE0008E3 at `pc`=0x0 → `imm`=0xFFFFFFFFFFFFFFF0, `target`=0xFFFFFFFFFFFFFFF0 (wrap).
- SUB (32), back to back with ADD: 0x40208033 followed next cycle by 0x00208033 → `op_id` 32 then 31 on consecutive cycles, `rd`=0 for both.
- Halt and illegal: 0x00000000 → `halt`=1, `op_id`=53. 0x0000007F → `illegal`=1, `op_id`=0. 0x0200101B (SLLIW with `instr[25]`=1) → `illegal`=1.
- Reset mid-stream: present 0x00500093 and assert `reset` the same edge → `out_valid`=0, all outputs 0. Deassert reset → next valid input decodes normally.

Source files
------------

// File: rtl/decoder.sv
// ---------------------------------------------------------------------------
// decoder
//   RV64I instruction decoder for the fetch/decode front end. One instruction
//   word plus its PC is accepted per cycle; the decode result appears one
//   clock later, fully registered.
//
// Ports
//   clk        in   1      rising-edge clock
//   reset      in   1      synchronous, active-high; clears every output
//   in_valid   in   1      instr/pc valid this cycle
//   instr      in   32     instruction word
//   pc         in   XLEN   address of instr
//   out_valid  out  1      decode outputs valid
//   op_id      out  6      mnemonic ID (0 = illegal, 53 = halt)
//   rd/rs1/rs2 out  5      register fields, zero when the format lacks them
//   funct3     out  3      instr[14:12]
//   funct7     out  7      instr[31:25]
//   imm        out  XLEN   sign-extended immediate (zero-extended shamt)
//   target     out  XLEN   pc+imm for branches, JAL and AUIPC, else zero
//   out_pc     out  XLEN   registered copy of pc
//   illegal    out  1      encoding not recognised
//   halt       out  1      all-zero instruction word
// ---------------------------------------------------------------------------
module decoder #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] pc,
    output logic            out_valid,
    output logic [5:0]      op_id,
    output logic [4:0]      rd,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [2:0]      funct3,
    output logic [6:0]      funct7,
    output logic [XLEN-1:0] imm,
    output logic [XLEN-1:0] target,
    output logic [XLEN-1:0] out_pc,
    output logic            illegal,
    output logic            halt
);

    // Mnemonic IDs
    localparam logic [5:0] OP_ILLEGAL = 6'd0,  OP_LUI   = 6'd1,  OP_AUIPC = 6'd2;
    localparam logic [5:0] OP_JAL     = 6'd3,  OP_JALR  = 6'd4;
    localparam logic [5:0] OP_BEQ     = 6'd5,  OP_BNE   = 6'd6,  OP_BLT   = 6'd7;
    localparam logic [5:0] OP_BGE     = 6'd8,  OP_BLTU  = 6'd9,  OP_BGEU  = 6'd10;
    localparam logic [5:0] OP_LB      = 6'd11, OP_LH    = 6'd12, OP_LW    = 6'd13;
    localparam logic [5:0] OP_LD      = 6'd14, OP_LBU   = 6'd15, OP_LHU   = 6'd16;
    localparam logic [5:0] OP_LWU     = 6'd17;
    localparam logic [5:0] OP_SB      = 6'd18, OP_SH    = 6'd19, OP_SW    = 6'd20;
    localparam logic [5:0] OP_SD      = 6'd21;
    localparam logic [5:0] OP_ADDI    = 6'd22, OP_SLTI  = 6'd23, OP_SLTIU = 6'd24;
    localparam logic [5:0] OP_XORI    = 6'd25, OP_ORI   = 6'd26, OP_ANDI  = 6'd27;
    localparam logic [5:0] OP_SLLI    = 6'd28, OP_SRLI  = 6'd29, OP_SRAI  = 6'd30;
    localparam logic [5:0] OP_ADD     = 6'd31, OP_SUB   = 6'd32, OP_SLL   = 6'd33;
    localparam logic [5:0] OP_SLT     = 6'd34, OP_SLTU  = 6'd35, OP_XOR   = 6'd36;
    localparam logic [5:0] OP_SRL     = 6'd37, OP_SRA   = 6'd38, OP_OR    = 6'd39;
    localparam logic [5:0] OP_AND     = 6'd40;
    localparam logic [5:0] OP_ADDIW   = 6'd41, OP_SLLIW = 6'd42, OP_SRLIW = 6'd43;
    localparam logic [5:0] OP_SRAIW   = 6'd44;
    localparam logic [5:0] OP_ADDW    = 6'd45, OP_SUBW  = 6'd46, OP_SLLW  = 6'd47;
    localparam logic [5:0] OP_SRLW    = 6'd48, OP_SRAW  = 6'd49;
    localparam logic [5:0] OP_FENCE   = 6'd50, OP_ECALL = 6'd51, OP_EBREAK = 6'd52;
    localparam logic [5:0] OP_HALT    = 6'd53;

    // Major opcodes
    localparam logic [6:0] OPC_LUI    = 7'b0110111, OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111, OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011, OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011, OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011, OPC_OPIMM32 = 7'b0011011;
    localparam logic [6:0] OPC_OP32   = 7'b0111011, OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    logic [6:0]      w_opcode;
    logic [2:0]      w_funct3;
    logic [6:0]      w_funct7;
    logic [XLEN-1:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
    logic [XLEN-1:0] w_shamt6, w_shamt5;

    logic [5:0]      w_op;
    logic            w_use_rd, w_use_rs1, w_use_rs2, w_has_tgt;
    logic [XLEN-1:0] w_imm_raw;

    logic            w_illegal, w_halt;
    logic [4:0]      w_rd, w_rs1, w_rs2;
    logic [XLEN-1:0] w_imm, w_target;

    logic            r_out_valid;
    logic [5:0]      r_op_id;
    logic [4:0]      r_rd, r_rs1, r_rs2;
    logic [2:0]      r_funct3;
    logic [6:0]      r_funct7;
    logic [XLEN-1:0] r_imm, r_target, r_out_pc;
    logic            r_illegal, r_halt;

    assign w_opcode = instr[6:0];
    assign w_funct3 = instr[14:12];
    assign w_funct7 = instr[31:25];

    // Immediate formats, all sign-extended from instr[31]
    assign w_imm_i  = {{(XLEN-12){instr[31]}}, instr[31:20]};
    assign w_imm_s  = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
    assign w_imm_b  = {{(XLEN-13){instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign w_imm_u  = {{(XLEN-32){instr[31]}}, instr[31:12], 12'd0};
    assign w_imm_j  = {{(XLEN-21){instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    // Shift amounts are zero-extended: 6 bits for RV64 shifts, 5 for *W shifts
    assign w_shamt6 = {{(XLEN-6){1'b0}}, instr[25:20]};
    assign w_shamt5 = {{(XLEN-5){1'b0}}, instr[24:20]};

    // Classify the instruction word: mnemonic, used fields, immediate choice
    always_comb begin
        w_op      = OP_ILLEGAL;
        w_use_rd  = 1'b0;
        w_use_rs1 = 1'b0;
        w_use_rs2 = 1'b0;
        w_has_tgt = 1'b0;
        w_imm_raw = {XLEN{1'b0}};
        if (instr == 32'h0000_0000) begin
            w_op = OP_HALT;
        end else begin
            case (w_opcode)
                OPC_LUI: begin
                    w_op = OP_LUI;  w_use_rd = 1'b1; w_imm_raw = w_imm_u;
                end
                OPC_AUIPC: begin
                    w_op = OP_AUIPC; w_use_rd = 1'b1; w_imm_raw = w_imm_u; w_has_tgt = 1'b1;
                end
                OPC_JAL: begin
                    w_op = OP_JAL;  w_use_rd = 1'b1; w_imm_raw = w_imm_j; w_has_tgt = 1'b1;
                end
                OPC_JALR: begin
                    w_use_rd = 1'b1; w_use_rs1 = 1'b1; w_imm_raw = w_imm_i;
                    case (w_funct3)
                        3'b000:  w_op = OP_JALR;
                        default: w_op = OP_ILLEGAL;
                    endcase
                end
                OPC_BRANCH: begin
                    w_use_rs1 = 1'b1; w_use_rs2 = 1'b1; w_imm_raw = w_imm_b; w_has_tgt = 1'b1;
                    case (w_funct3)
                        3'b000:  w_op = OP_BEQ;
                        3'b001:  w_op = OP_BNE;
                        3'b100:  w_op = OP_BLT;
                        3'b101:  w_op = OP_BGE;
                        3'b110:  w_op = OP_BLTU;
                        3'b111:  w_op = OP_BGEU;
                        default: w_op = OP_ILLEGAL;
                    endcase
                end
                OPC_LOAD: begin
                    w_use_rd = 1'b1; w_use_rs1 = 1'b1; w_imm_raw = w_imm_i;
                    case (w_funct3)
                        3'b000:  w_op = OP_LB;
                        3'b001:  w_op = OP_LH;
                        3'b010:  w_op = OP_LW;
                        3'b011:  w_op = OP_LD;
                        3'b100:  w_op = OP_LBU;
                        3'b101:  w_op = OP_LHU;
                        3'b110:  w_op = OP_LWU;
                        default: w_op = OP_ILLEGAL;
                    endcase
                end
                OPC_STORE: begin
                    w_use_rs1 = 1'b1; w_use_rs2 = 1'b1; w_imm_raw = w_imm_s;
                    case (w_funct3)
                        3'b000:  w_op = OP_SB;
                        3'b001:  w_op = OP_SH;
                        3'b010:  w_op = OP_SW;
                        3'b011:  w_op = OP_SD;
                        default: w_op = OP_ILLEGAL;
                    endcase
                end
                OPC_OPIMM: begin
                    w_use_rd = 1'b1; w_use_rs1 = 1'b1; w_imm_raw = w_imm_i;
                    // RV64 shifts carry a 6-bit shamt, so only funct6 is checked
                    case (w_funct3)
                        3'b000:  w_op = OP_ADDI;
                        3'b010:  w_op = OP_SLTI;
                        3'b011:  w_op = OP_SLTIU;
                        3'b100:  w_op = OP_XORI;
                        3'b110:  w_op = OP_ORI;
                        3'b111:  w_op = OP_ANDI;
                        3'b001: begin
                            w_imm_raw = w_shamt6;
                            case (instr[31:26])
                                6'b000000: w_op = OP_SLLI;
                                default:   w_op = OP_ILLEGAL;
                            endcase
                        end
                        3'b101: begin
                            w_imm_raw = w_shamt6;
                            case (instr[31:26])
                                6'b000000: w_op = OP_SRLI;
                                6'b010000: w_op = OP_SRAI;
                                default:   w_op = OP_ILLEGAL;
                            endcase
                        end
                        default: w_op = OP_ILLEGAL;
                    endcase
                end
                OPC_OP: begin
                    w_use_rd = 1'b1; w_use_rs1 = 1'b1; w_use_rs2 = 1'b1;
                    case ({w_funct7, w_funct3})
                        10'b0000000_000: w_op = OP_ADD;
                        10'b0100000_000: w_op = OP_SUB;
                        10'b0000000_001: w_op = OP_SLL;
                        10'b0000000_010: w_op = OP_SLT;
                        10'b0000000_011: w_op = OP_SLTU;
                        10'b0000000_100: w_op = OP_XOR;
                        10'b0000000_101: w_op = OP_SRL;
                        10'b0100000_101: w_op = OP_SRA;
                        10'b0000000_110: w_op = OP_OR;
                        10'b0000000_111: w_op = OP_AND;
                        default:         w_op = OP_ILLEGAL;
                    endcase
                end
                OPC_OPIMM32: begin
                    w_use_rd = 1'b1; w_use_rs1 = 1'b1;
                    // *W shifts use a 5-bit shamt; instr[25] is part of funct7
                    case (w_funct3)
                        3'b000: begin
                            w_op = OP_ADDIW; w_imm_raw = w_imm_i;
                        end
                        3'b001: begin
                            w_imm_raw = w_shamt5;
                            case (w_funct7)
                                7'b0000000: w_op = OP_SLLIW;
                                default:    w_op = OP_ILLEGAL;
                            endcase
                        end
                        3'b101: begin
                            w_imm_raw = w_shamt5;
                            case (w_funct7)
                                7'b0000000: w_op = OP_SRLIW;
                                7'b0100000: w_op = OP_SRAIW;
                                default:    w_op = OP_ILLEGAL;
                            endcase
                        end
                        default: w_op = OP_ILLEGAL;
                    endcase
                end
                OPC_OP32: begin
                    w_use_rd = 1'b1; w_use_rs1 = 1'b1; w_use_rs2 = 1'b1;
                    case ({w_funct7, w_funct3})
                        10'b0000000_000: w_op = OP_ADDW;
                        10'b0100000_000: w_op = OP_SUBW;
                        10'b0000000_001: w_op = OP_SLLW;
                        10'b0000000_101: w_op = OP_SRLW;
                        10'b0100000_101: w_op = OP_SRAW;
                        default:         w_op = OP_ILLEGAL;
                    endcase
                end
                OPC_FENCE: begin
                    w_use_rd = 1'b1; w_use_rs1 = 1'b1; w_imm_raw = w_imm_i;
                    case (w_funct3)
                        3'b000:  w_op = OP_FENCE;
                        default: w_op = OP_ILLEGAL;
                    endcase
                end
                OPC_SYSTEM: begin
                    // Only the two exact encodings are accepted
                    case (instr)
                        32'h0000_0073: w_op = OP_ECALL;
                        32'h0010_0073: w_op = OP_EBREAK;
                        default:       w_op = OP_ILLEGAL;
                    endcase
                end
                default: w_op = OP_ILLEGAL;
            endcase
        end
    end

    // Illegal words keep their raw register fields but report no immediate/target
    always_comb begin
        w_illegal = (w_op == OP_ILLEGAL);
        w_halt    = (w_op == OP_HALT);
        w_rd      = (w_illegal || w_use_rd)  ? instr[11:7]  : 5'd0;
        w_rs1     = (w_illegal || w_use_rs1) ? instr[19:15] : 5'd0;
        w_rs2     = (w_illegal || w_use_rs2) ? instr[24:20] : 5'd0;
        w_imm     = w_illegal ? {XLEN{1'b0}} : w_imm_raw;
        // Wrap-around of pc+imm is intentional
        w_target  = (w_has_tgt && !w_illegal) ? (pc + w_imm) : {XLEN{1'b0}};
    end

    // Output register: cleared by reset, loaded on in_valid, data held when idle
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_op_id     <= 6'd0;
            r_rd        <= 5'd0;
            r_rs1       <= 5'd0;
            r_rs2       <= 5'd0;
            r_funct3    <= 3'd0;
            r_funct7    <= 7'd0;
            r_imm       <= {XLEN{1'b0}};
            r_target    <= {XLEN{1'b0}};
            r_out_pc    <= {XLEN{1'b0}};
            r_illegal   <= 1'b0;
            r_halt      <= 1'b0;
        end else if (in_valid) begin
            r_out_valid <= 1'b1;
            r_op_id     <= w_op;
            r_rd        <= w_rd;
            r_rs1       <= w_rs1;
            r_rs2       <= w_rs2;
            r_funct3    <= w_funct3;
            r_funct7    <= w_funct7;
            r_imm       <= w_imm;
            r_target    <= w_target;
            r_out_pc    <= pc;
            r_illegal   <= w_illegal;
            r_halt      <= w_halt;
        end else begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign op_id     = r_op_id;
    assign rd        = r_rd;
    assign rs1       = r_rs1;
    assign rs2       = r_rs2;
    assign funct3    = r_funct3;
    assign funct7    = r_funct7;
    assign imm       = r_imm;
    assign target    = r_target;
    assign out_pc    = r_out_pc;
    assign illegal   = r_illegal;
    assign halt      = r_halt;

endmodule

// File: tb/tb_decoder.sv
module tb_decoder;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [31:0] instr;
    logic [63:0] pc;
    logic        out_valid;
    logic [5:0]  op_id;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [63:0] imm, target, out_pc;
    logic        illegal, halt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] instr;
        logic [63:0] pc;
        logic [5:0]  op;
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [63:0] imm, tgt;
        logic        ill, hlt;
    } exp_t;

    exp_t        sb[$];
    logic [5:0]  last_op = 6'd0;

    decoder #(.XLEN(64)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .instr(instr), .pc(pc),
        .out_valid(out_valid), .op_id(op_id), .rd(rd), .rs1(rs1), .rs2(rs2),
        .funct3(funct3), .funct7(funct7), .imm(imm), .target(target),
        .out_pc(out_pc), .illegal(illegal), .halt(halt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input logic [5:0] op, input logic [4:0] e_rd,
                                input logic [4:0] e_rs1, input logic [4:0] e_rs2,
                                input logic [2:0] f3, input logic [6:0] f7,
                                input logic [63:0] e_imm, input logic [63:0] e_tgt,
                                input logic ill, input logic hlt);
        exp_t e;
        e.instr = 32'd0; e.pc = 64'd0;
        e.op = op; e.rd = e_rd; e.rs1 = e_rs1; e.rs2 = e_rs2;
        e.f3 = f3; e.f7 = f7; e.imm = e_imm; e.tgt = e_tgt;
        e.ill = ill; e.hlt = hlt;
        return e;
    endfunction

    // Compare outputs against the scoreboard head (or idle expectations)
    task automatic check_out();
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("out_valid", {63'd0, out_valid}, 64'd1);
            chk("op_id",   {58'd0, op_id},  {58'd0, e.op});
            chk("rd",      {59'd0, rd},     {59'd0, e.rd});
            chk("rs1",     {59'd0, rs1},    {59'd0, e.rs1});
            chk("rs2",     {59'd0, rs2},    {59'd0, e.rs2});
            chk("funct3",  {61'd0, funct3}, {61'd0, e.f3});
            chk("funct7",  {57'd0, funct7}, {57'd0, e.f7});
            chk("imm",     imm,    e.imm);
            chk("target",  target, e.tgt);
            chk("out_pc",  out_pc, e.pc);
            chk("illegal", {63'd0, illegal}, {63'd0, e.ill});
            chk("halt",    {63'd0, halt},    {63'd0, e.hlt});
            last_op = e.op;
            $display("TRACE pc=%h instr=%h op_id=%0d rd=x%0d rs1=x%0d rs2=x%0d imm=%h",
                     out_pc, e.instr, op_id, rd, rs1, rs2, imm);
        end else begin
            chk("out_valid_idle", {63'd0, out_valid}, 64'd0);
            chk("hold_op_id", {58'd0, op_id}, {58'd0, last_op});
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_valid"},  {63'd0, out_valid}, 64'd0);
        chk({tag, "_op"},     {58'd0, op_id}, 64'd0);
        chk({tag, "_regs"},   {49'd0, rd, rs1, rs2}, 64'd0);
        chk({tag, "_funct"},  {54'd0, funct3, funct7}, 64'd0);
        chk({tag, "_imm"},    imm, 64'd0);
        chk({tag, "_target"}, target, 64'd0);
        chk({tag, "_pc"},     out_pc, 64'd0);
        chk({tag, "_flags"},  {62'd0, illegal, halt}, 64'd0);
    endtask

    task automatic send(input logic [31:0] i, input logic [63:0] p, input exp_t e);
        exp_t q;
        q = e;
        q.instr = i;
        q.pc = p;
        instr = i; pc = p; in_valid = 1'b1;
        sb.push_back(q);
        @(posedge clk); #1;
        check_out();
    endtask

    task automatic idle();
        in_valid = 1'b0;
        @(posedge clk); #1;
        check_out();
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; instr = 32'd0; pc = 64'd0;
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        reset = 1'b0;

        // ADDI positive / negative immediates, back to back
        send(32'h0050_0093, 64'h1000, mk(6'd22, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 64'd5, 64'd0, 1'b0, 1'b0));
        send(32'hFFF0_0113, 64'h1004, mk(6'd22, 5'd2, 5'd0, 5'd0, 3'd0, 7'h7F, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0, 1'b0));
        // BEQ forward, then backward branch at pc 0 wrapping the target
        send(32'h0020_8463, 64'h1000, mk(6'd5, 5'd0, 5'd1, 5'd2, 3'd0, 7'h00, 64'd8, 64'h1008, 1'b0, 1'b0));
        send(32'hFE00_08E3, 64'h0, mk(6'd5, 5'd0, 5'd0, 5'd0, 3'd0, 7'h7F, 64'hFFFF_FFFF_FFFF_FFF0, 64'hFFFF_FFFF_FFFF_FFF0, 1'b0, 1'b0));
        // SUB then ADD on consecutive cycles
        send(32'h4020_8033, 64'h2000, mk(6'd32, 5'd0, 5'd1, 5'd2, 3'd0, 7'h20, 64'd0, 64'd0, 1'b0, 1'b0));
        send(32'h0020_8033, 64'h2004, mk(6'd31, 5'd0, 5'd1, 5'd2, 3'd0, 7'h00, 64'd0, 64'd0, 1'b0, 1'b0));
        idle();
        // Halt, unknown opcode, SLLIW with instr[25]=1
        send(32'h0000_0000, 64'h3000, mk(6'd53, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 64'd0, 64'd0, 1'b0, 1'b1));
        send(32'h0000_007F, 64'h3004, mk(6'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 64'd0, 64'd0, 1'b1, 1'b0));
        send(32'h0200_101B, 64'h3008, mk(6'd0, 5'd0, 5'd0, 5'd0, 3'd1, 7'h01, 64'd0, 64'd0, 1'b1, 1'b0));
        // LUI with bit 31 set, JAL, SRAI with 6-bit shamt
        send(32'h8000_02B7, 64'h4000, mk(6'd1, 5'd5, 5'd0, 5'd0, 3'd0, 7'h40, 64'hFFFF_FFFF_8000_0000, 64'd0, 1'b0, 1'b0));
        send(32'h0080_00EF, 64'h2000, mk(6'd3, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 64'd8, 64'h2008, 1'b0, 1'b0));
        send(32'h4030_D093, 64'h4008, mk(6'd30, 5'd1, 5'd1, 5'd0, 3'd5, 7'h20, 64'd3, 64'd0, 1'b0, 1'b0));
        // System: ECALL, EBREAK, and a non-exact SYSTEM word
        send(32'h0000_0073, 64'h5000, mk(6'd51, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 64'd0, 64'd0, 1'b0, 1'b0));
        send(32'h0010_0073, 64'h5004, mk(6'd52, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 64'd0, 64'd0, 1'b0, 1'b0));
        send(32'h0020_0073, 64'h5008, mk(6'd0, 5'd0, 5'd0, 5'd2, 3'd0, 7'h00, 64'd0, 64'd0, 1'b1, 1'b0));
        // SD and LWU
        send(32'h0011_3423, 64'h6000, mk(6'd21, 5'd0, 5'd2, 5'd1, 3'd3, 7'h00, 64'd8, 64'd0, 1'b0, 1'b0));
        send(32'h0000_6083, 64'h6004, mk(6'd17, 5'd1, 5'd0, 5'd0, 3'd6, 7'h00, 64'd0, 64'd0, 1'b0, 1'b0));

        // Reset mid-stream: previous result in flight, new input on the reset edge
        reset = 1'b1; instr = 32'h0050_0093; pc = 64'h7000; in_valid = 1'b1;
        @(posedge clk); #1;
        check_zero("midreset");
        reset = 1'b0;
        send(32'h0050_0093, 64'h7004, mk(6'd22, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 64'd5, 64'd0, 1'b0, 1'b0));
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
